// File: rtl/phase_detector_multi_start_stop.sv
// Multi-channel start/stop phase detector: a synced reference edge starts every channel's
// counter, a synced channel edge stops it, and tags are merged round-robin onto one stream.

module sync_2ff (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);
   logic meta;

   // two-stage synchronizer for an asynchronous level
   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end
endmodule

module phase_detector_multi_start_stop #(
   parameter  int NUM_CH           = 4,
   parameter  int PHASE_COUNT_SIZE = 28,
   parameter  int DROP_COUNT_SIZE  = 16,
   localparam int CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic                        clk_sample,
   input  logic                        rst,
   input  logic                        en,
   input  logic                        clk_ref,
   input  logic [NUM_CH-1:0]           clk_in,
   output logic                        tag_valid,
   input  logic                        tag_ready,
   output logic [PHASE_COUNT_SIZE-1:0] tag,
   output logic [CH_W-1:0]             tag_ch,
   output logic                        tag_ovf,
   output logic [DROP_COUNT_SIZE-1:0]  drop_count
);
   localparam logic [PHASE_COUNT_SIZE-1:0] CNT_ZERO = {PHASE_COUNT_SIZE{1'b0}};
   localparam logic [PHASE_COUNT_SIZE-1:0] CNT_ONE  = {{(PHASE_COUNT_SIZE-1){1'b0}}, 1'b1};
   localparam logic [PHASE_COUNT_SIZE-1:0] CNT_MAX  = {PHASE_COUNT_SIZE{1'b1}};
   localparam logic [DROP_COUNT_SIZE-1:0]  DROP_MAX = {DROP_COUNT_SIZE{1'b1}};
   localparam int                          DSUM_W   = DROP_COUNT_SIZE + 5;

   typedef enum logic {S_IDLE = 1'b0, S_COUNT = 1'b1} state_t;

   logic                        ref_sync, ref_dly, ref_edge;
   logic [NUM_CH-1:0]           in_sync, in_dly, ch_edge;
   state_t                      state     [NUM_CH];
   state_t                      state_nxt [NUM_CH];
   logic [PHASE_COUNT_SIZE-1:0] cnt       [NUM_CH];
   logic [PHASE_COUNT_SIZE-1:0] cnt_nxt   [NUM_CH];
   logic [PHASE_COUNT_SIZE-1:0] cap_tag   [NUM_CH];
   logic [PHASE_COUNT_SIZE-1:0] slot_tag  [NUM_CH];
   logic [NUM_CH-1:0]           cap, cap_ovf, slot_full, slot_ovf;
   logic [CH_W-1:0]             last_ch, grant_ch;
   logic                        load, found, grant;
   logic [4:0]                  drop_num;
   logic [DSUM_W-1:0]           drop_sum;

   function automatic logic [CH_W-1:0] rr_idx(input logic [CH_W-1:0] base, input int offset);
      return CH_W'((int'(base) + offset) % NUM_CH);
   endfunction

   sync_2ff u_ref_sync (.clk(clk_sample), .rst(rst), .d(clk_ref), .q(ref_sync));

   for (genvar g = 0; g < NUM_CH; g++) begin : g_in_sync
      sync_2ff u_sync (.clk(clk_sample), .rst(rst), .d(clk_in[g]), .q(in_sync[g]));
   end

   // delay registers for rising-edge detection on the synced inputs
   always_ff @(posedge clk_sample) begin
      if (rst) begin
         ref_dly <= 1'b0;
         in_dly  <= {NUM_CH{1'b0}};
      end else begin
         ref_dly <= ref_sync;
         in_dly  <= in_sync;
      end
   end

   assign ref_edge = ref_sync & ~ref_dly;
   assign ch_edge  = in_sync & ~in_dly;

   // per-channel start/stop FSM; a restart by a lone ref edge discards the old count silently
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         state_nxt[i] = state[i];
         cnt_nxt[i]   = cnt[i];
         cap[i]       = 1'b0;
         cap_tag[i]   = CNT_ZERO;
         cap_ovf[i]   = 1'b0;
         if (!en) begin
            state_nxt[i] = S_IDLE;
            cnt_nxt[i]   = CNT_ZERO;
         end else begin
            case (state[i])
               S_IDLE: begin
                  if (ref_edge && ch_edge[i]) begin
                     cap[i] = 1'b1;
                  end else if (ref_edge) begin
                     cnt_nxt[i]   = CNT_ONE;
                     state_nxt[i] = S_COUNT;
                  end else begin
                     state_nxt[i] = S_IDLE;
                  end
               end
               S_COUNT: begin
                  if (ch_edge[i]) begin
                     cap[i]     = 1'b1;
                     cap_tag[i] = cnt[i];
                     if (ref_edge) begin
                        cnt_nxt[i] = CNT_ONE;
                     end else begin
                        cnt_nxt[i]   = CNT_ZERO;
                        state_nxt[i] = S_IDLE;
                     end
                  end else if (ref_edge) begin
                     cnt_nxt[i] = CNT_ONE;
                  end else if (cnt[i] == CNT_MAX) begin
                     cap[i]       = 1'b1;
                     cap_tag[i]   = CNT_MAX;
                     cap_ovf[i]   = 1'b1;
                     cnt_nxt[i]   = CNT_ZERO;
                     state_nxt[i] = S_IDLE;
                  end else begin
                     cnt_nxt[i] = cnt[i] + CNT_ONE;
                  end
               end
               default: begin
                  state_nxt[i] = S_IDLE;
                  cnt_nxt[i]   = CNT_ZERO;
               end
            endcase
         end
      end
   end

   // channel state and counter registers
   always_ff @(posedge clk_sample) begin
      for (int i = 0; i < NUM_CH; i++) begin
         if (rst) begin
            state[i] <= S_IDLE;
            cnt[i]   <= CNT_ZERO;
         end else begin
            state[i] <= state_nxt[i];
            cnt[i]   <= cnt_nxt[i];
         end
      end
   end

   // round-robin search starting after the last granted channel
   always_comb begin
      found    = 1'b0;
      grant_ch = {CH_W{1'b0}};
      for (int k = 1; k <= NUM_CH; k++) begin
         if (!found && slot_full[rr_idx(last_ch, k)]) begin
            found    = 1'b1;
            grant_ch = rr_idx(last_ch, k);
         end else begin
            found = found;
         end
      end
   end

   assign load  = ~tag_valid | tag_ready;
   assign grant = load & found;

   // count overwrites of full slots that are not draining this cycle
   always_comb begin
      drop_num = 5'd0;
      for (int i = 0; i < NUM_CH; i++) begin
         if (cap[i] && slot_full[i] && !(grant && (grant_ch == CH_W'(i)))) begin
            drop_num = drop_num + 5'd1;
         end else begin
            drop_num = drop_num;
         end
      end
      drop_sum = {5'd0, drop_count} + {{DROP_COUNT_SIZE{1'b0}}, drop_num};
   end

   // pending slots, drop counter and output register
   always_ff @(posedge clk_sample) begin
      if (rst) begin
         for (int i = 0; i < NUM_CH; i++) begin
            slot_tag[i] <= CNT_ZERO;
         end
         slot_full  <= {NUM_CH{1'b0}};
         slot_ovf   <= {NUM_CH{1'b0}};
         drop_count <= {DROP_COUNT_SIZE{1'b0}};
         tag_valid  <= 1'b0;
         tag        <= CNT_ZERO;
         tag_ch     <= {CH_W{1'b0}};
         tag_ovf    <= 1'b0;
         last_ch    <= CH_W'(NUM_CH - 1);
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            if (cap[i]) begin
               slot_full[i] <= 1'b1;
               slot_tag[i]  <= cap_tag[i];
               slot_ovf[i]  <= cap_ovf[i];
            end else if (grant && (grant_ch == CH_W'(i))) begin
               slot_full[i] <= 1'b0;
            end else begin
               slot_full[i] <= slot_full[i];
            end
         end
         if (drop_sum > {5'd0, DROP_MAX}) begin
            drop_count <= DROP_MAX;
         end else begin
            drop_count <= drop_sum[DROP_COUNT_SIZE-1:0];
         end
         if (grant) begin
            tag_valid <= 1'b1;
            tag       <= slot_tag[grant_ch];
            tag_ch    <= grant_ch;
            tag_ovf   <= slot_ovf[grant_ch];
            last_ch   <= grant_ch;
         end else if (load) begin
            tag_valid <= 1'b0;
         end else begin
            tag_valid <= tag_valid;
         end
      end
   end
endmodule

// File: tb/tb_phase_detector_multi_start_stop.sv
// Randomized and directed bench for phase_detector_multi_start_stop, checked every cycle
// against a timestamp-based reference model (tag = stop cycle - start cycle).

module tb_phase_detector_multi_start_stop;
   localparam int NCH  = 4;
   localparam int PCS  = 4;
   localparam int DCS  = 4;
   localparam int TMAX = 15;
   localparam int DMAX = 15;
   localparam int MAXC = 8192;

   logic           clk_sample = 1'b0;
   logic           rst, en, clk_ref, tag_ready;
   logic [NCH-1:0] clk_in;
   logic           tag_valid, tag_ovf;
   logic [PCS-1:0] tag;
   logic [1:0]     tag_ch;
   logic [DCS-1:0] drop_count;

   int checks = 0;
   int errors = 0;

   phase_detector_multi_start_stop #(
      .NUM_CH(NCH), .PHASE_COUNT_SIZE(PCS), .DROP_COUNT_SIZE(DCS)
   ) dut (
      .clk_sample(clk_sample), .rst(rst), .en(en), .clk_ref(clk_ref), .clk_in(clk_in),
      .tag_valid(tag_valid), .tag_ready(tag_ready), .tag(tag), .tag_ch(tag_ch),
      .tag_ovf(tag_ovf), .drop_count(drop_count)
   );

   always #5 clk_sample = ~clk_sample;

   // reference model: channels remember the cycle they were started
   bit             m_act   [NCH];
   int             m_start [NCH];
   bit             m_full  [NCH];
   int             m_tag   [NCH];
   bit             m_sovf  [NCH];
   bit             o_valid, o_ovf;
   int             o_tag, o_ch, m_last, m_drops;
   int             cyc = 0;
   int             rst_cyc = -1;
   bit             ref_h [MAXC];
   logic [NCH-1:0] in_h  [MAXC];

   task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cyc);
      end
   endtask

   function automatic bit ref_at(input int j);
      if (j < 0 || j <= rst_cyc) return 1'b0;
      return ref_h[j];
   endfunction

   function automatic bit in_at(input int j, input int i);
      if (j < 0 || j <= rst_cyc) return 1'b0;
      return in_h[j][i];
   endfunction

   task automatic model_step();
      bit re, load, found;
      bit ce [NCH];
      bit cap [NCH];
      bit covf [NCH];
      int ctag [NCH];
      int g, j, age;
      ref_h[cyc] = clk_ref;
      in_h[cyc]  = clk_in;
      if (rst) begin
         for (int i = 0; i < NCH; i++) begin
            m_act[i]  = 1'b0;
            m_full[i] = 1'b0;
         end
         o_valid = 1'b0; o_tag = 0; o_ch = 0; o_ovf = 1'b0;
         m_last = NCH - 1; m_drops = 0; rst_cyc = cyc;
      end else begin
         // an input level seen in cycle c becomes an edge event two cycles later
         re = ref_at(cyc - 2) && !ref_at(cyc - 3);
         for (int i = 0; i < NCH; i++) begin
            ce[i] = in_at(cyc - 2, i) && !in_at(cyc - 3, i);
            cap[i] = 1'b0; ctag[i] = 0; covf[i] = 1'b0;
            age = cyc - m_start[i];
            if (!en) begin
               m_act[i] = 1'b0;
            end else if (!m_act[i]) begin
               if (re && ce[i]) cap[i] = 1'b1;
               else if (re) begin m_act[i] = 1'b1; m_start[i] = cyc; end
            end else if (ce[i]) begin
               cap[i] = 1'b1; ctag[i] = age;
               if (re) m_start[i] = cyc; else m_act[i] = 1'b0;
            end else if (re) begin
               m_start[i] = cyc;
            end else if (age == TMAX) begin
               cap[i] = 1'b1; ctag[i] = TMAX; covf[i] = 1'b1; m_act[i] = 1'b0;
            end
         end
         load = !o_valid || tag_ready;
         found = 1'b0; g = 0;
         if (load) begin
            for (int k = 1; k <= NCH; k++) begin
               j = (m_last + k) % NCH;
               if (!found && m_full[j]) begin found = 1'b1; g = j; end
            end
            if (found) begin
               o_valid = 1'b1; o_tag = m_tag[g]; o_ch = g; o_ovf = m_sovf[g]; m_last = g;
            end else begin
               o_valid = 1'b0;
            end
         end
         for (int i = 0; i < NCH; i++) begin
            if (cap[i]) begin
               if (m_full[i] && !(found && g == i)) m_drops = (m_drops < DMAX) ? m_drops + 1 : DMAX;
               m_full[i] = 1'b1; m_tag[i] = ctag[i]; m_sovf[i] = covf[i];
            end else if (found && g == i) begin
               m_full[i] = 1'b0;
            end
         end
      end
      cyc++;
   endtask

   task automatic step();
      @(posedge clk_sample);
      if (cyc >= MAXC) begin
         $display("FAIL cycle_budget: got %0d cycles, expected below %0d", cyc, MAXC);
         $fatal(1, "cycle budget exhausted");
      end
      model_step();
      #1;
      check("valid", tag_valid, o_valid);
      if (o_valid) begin
         check("tag", tag, o_tag);
         check("tag_ch", tag_ch, o_ch);
         check("tag_ovf", tag_ovf, o_ovf);
      end
      check("drop_count", drop_count, m_drops);
   endtask

   // ref edge at the current cycle, stop edge on mask exactly gap cycles later (gap >= 1)
   task automatic measure(input logic [NCH-1:0] mask, input int gap);
      clk_ref = 1'b1;
      step();
      clk_ref = 1'b0;
      repeat (gap - 1) step();
      clk_in = mask;
      step();
      clk_in = '0;
      step();
   endtask

   task automatic wait_valid(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (tag_valid) begin ok = 1'b1; break; end
         step();
      end
   endtask

   initial begin
      bit ok;
      rst = 1'b1; en = 1'b0; clk_ref = 1'b0; clk_in = '0; tag_ready = 1'b1;
      repeat (3) step();
      check("rst_valid", tag_valid, 0);
      check("rst_tag", tag, 0);
      check("rst_tag_ch", tag_ch, 0);
      check("rst_ovf", tag_ovf, 0);
      check("rst_drop", drop_count, 0);
      rst = 1'b0; en = 1'b1;
      repeat (4) step();

      // stop on ch2 ten cycles after ref; tag appears 2 cycles after the synced stop edge
      measure(4'b0100, 10);
      step();
      check("t1_early", tag_valid, 0);
      step();
      check("t1_valid", tag_valid, 1);
      check("t1_tag", tag, 10);
      check("t1_ch", tag_ch, 2);
      check("t1_ovf", tag_ovf, 0);

      // the other channels never saw a stop edge and saturate
      step();
      wait_valid(ok);
      check("t3_seen", ok, 1);
      check("t3_tag", tag, 15);
      check("t3_ovf", tag_ovf, 1);
      check("t3_ch", tag_ch, 3);
      repeat (3) step();
      for (int i = 0; i < 5; i++) begin
         check("t3_idle", tag_valid, 0);
         step();
      end

      // ref and stop in the same cycle
      clk_ref = 1'b1; clk_in = 4'b0001;
      step();
      clk_ref = 1'b0; clk_in = '0;
      wait_valid(ok);
      check("t2_seen", ok, 1);
      check("t2_tag", tag, 0);
      check("t2_ch", tag_ch, 0);
      repeat (25) step();

      // simultaneous stops on ch1 and ch3
      measure(4'b1010, 5);
      step(); step();
      check("t4_first_valid", tag_valid, 1);
      check("t4_first_ch", tag_ch, 1);
      check("t4_first_tag", tag, 5);
      step();
      check("t4_second_valid", tag_valid, 1);
      check("t4_second_ch", tag_ch, 3);
      check("t4_second_tag", tag, 5);
      step();
      wait_valid(ok);
      check("t4_tie_seen", ok, 1);
      check("t4_tie_ch", tag_ch, 0);
      check("t4_tie_ovf", tag_ovf, 1);
      step();
      check("t4_tie_next_ch", tag_ch, 2);
      repeat (10) step();

      // back-pressure: ch0 yields tags 3,4,5,6; 3 is held, 4 and 5 are overwritten
      tag_ready = 1'b0;
      measure(4'b0001, 3);
      measure(4'b0001, 4);
      measure(4'b0001, 5);
      measure(4'b0001, 6);
      step();
      check("t5_drop", drop_count, 2);
      check("t5_hold_valid", tag_valid, 1);
      check("t5_hold_tag", tag, 3);
      check("t5_hold_ch", tag_ch, 0);
      tag_ready = 1'b1;
      step();
      ok = 1'b0;
      for (int i = 0; i < 30; i++) begin
         if (!ok && tag_valid && tag_ch == 2'd0) begin
            check("t5_last_tag", tag, 6);
            ok = 1'b1;
         end
         step();
      end
      check("t5_last_seen", ok, 1);
      repeat (40) step();

      // enable dropped mid-count: that measurement produces nothing
      clk_ref = 1'b1; step(); clk_ref = 1'b0;
      repeat (4) step();
      en = 1'b0; step(); step(); en = 1'b1; step();
      clk_in = 4'b0010; step(); clk_in = '0;
      for (int i = 0; i < 20; i++) begin
         check("t6_en_quiet", tag_valid, 0);
         step();
      end

      // reset mid-count: discards the measurement and clears drop_count
      clk_ref = 1'b1; step(); clk_ref = 1'b0;
      repeat (5) step();
      rst = 1'b1; step(); rst = 1'b0;
      check("t6_rst_drop", drop_count, 0);
      clk_in = 4'b0010; step(); clk_in = '0;
      for (int i = 0; i < 20; i++) begin
         check("t6_rst_quiet", tag_valid, 0);
         step();
      end
      measure(4'b0010, 7);
      wait_valid(ok);
      check("t6_after_seen", ok, 1);
      check("t6_after_tag", tag, 7);
      check("t6_after_ch", tag_ch, 1);
      repeat (25) step();

      // random traffic, with a long back-pressure stretch to saturate drop_count
      for (int n = 0; n < 2400; n++) begin
         if ($urandom_range(0, 3) == 0) clk_ref = ~clk_ref;
         for (int i = 0; i < NCH; i++) begin
            if ($urandom_range(0, 4) == 0) clk_in[i] = ~clk_in[i];
         end
         tag_ready = (n >= 1000 && n < 1250) ? 1'b0 : ($urandom_range(0, 3) != 0);
         en = ($urandom_range(0, 59) != 0);
         rst = (n < 1000 || n >= 1250) && ($urandom_range(0, 399) == 0);
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
